// File: rtl/tg_pkg.sv
// Shared tgBASE constants, block type, FSM state enum and the ASCII -> 6-bit code map
// used by the pair packer.
package tg_pkg;

    localparam int TG_W  = 6;
    localparam int BLK_W = 14;
    localparam int RSA_N = 10403;

    localparam logic [6:0] SP_LO = 7'd32;
    localparam logic [6:0] SP_HI = 7'd33;
    localparam logic [6:0] DG_LO = 7'd48;
    localparam logic [6:0] DG_HI = 7'd57;
    localparam logic [6:0] UC_LO = 7'd65;
    localparam logic [6:0] UC_HI = 7'd90;
    localparam logic [6:0] LC_LO = 7'd97;
    localparam logic [6:0] LC_HI = 7'd122;

    localparam logic [6:0] SP_OFF = 7'd32;
    localparam logic [6:0] DG_OFF = 7'd46;
    localparam logic [6:0] UC_OFF = 7'd53;
    localparam logic [6:0] LC_OFF = 7'd59;

    typedef logic [BLK_W-1:0] tg_block_t;

    typedef enum logic {S_HI, S_LO} tg_state_e;

    function automatic logic tg_is_mapped(input logic [6:0] c);
        return (c >= SP_LO && c <= SP_HI) || (c >= DG_LO && c <= DG_HI) ||
               (c >= UC_LO && c <= UC_HI) || (c >= LC_LO && c <= LC_HI);
    endfunction

    function automatic logic [TG_W-1:0] ascii_to_tg(input logic [6:0] c);
        logic [6:0] off;
        // Subtracting the character from itself yields code 0 for unmapped input.
        off = c;
        if (c >= SP_LO && c <= SP_HI)      off = SP_OFF;
        else if (c >= DG_LO && c <= DG_HI) off = DG_OFF;
        else if (c >= UC_LO && c <= UC_HI) off = UC_OFF;
        else if (c >= LC_LO && c <= LC_HI) off = LC_OFF;
        return TG_W'(c - off);
    endfunction

    function automatic tg_block_t make_block(input logic [TG_W-1:0] hi,
                                             input logic [TG_W-1:0] lo);
        return {1'b0, hi, 1'b0, lo};
    endfunction

endpackage

// File: rtl/tg_sync_fifo.sv
// Small synchronous FIFO with registered storage and no bypass; the output word holds
// its last value while empty. DEPTH must be a power of 2 so pointers wrap naturally.
module tg_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full_nxt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        hold_d   = empty ? hold_q : mem_q[rd_ptr_q];
    end

    assign full_nxt = (count_d == CW'(DEPTH));
    // While empty the head slot is stale, so show the last word that was presented.
    assign rdata    = empty ? hold_q : mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/tg_pair_packer.sv
// Maps ASCII characters to tgBASE codes, pairs them into 14-bit plaintext blocks and
// queues the blocks for the RSA encryptor. Optional macro: TG_ILLEGAL_CNT_EN.
module tg_pair_packer
    import tg_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_char,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_block,
    output logic             out_last,
    output logic             out_pad,
    output logic [CNT_W-1:0] blk_cnt
`ifdef TG_ILLEGAL_CNT_EN
    ,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic             illegal_seen
`endif
);

    localparam int FW = BLK_W + 2;

    tg_state_e        state_q, state_d;
    logic [TG_W-1:0]  hi_q, hi_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             accept;
    logic [TG_W-1:0]  code;
    logic             push;
    tg_block_t        push_blk;
    logic             push_last;
    logic             push_pad;
    logic [FW-1:0]    fifo_rdata;
    logic             fifo_empty;
    logic             fifo_full_nxt;

    assign accept = in_valid && in_ready_q;
    assign code   = ascii_to_tg(in_char);

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        push      = 1'b0;
        push_blk  = '0;
        push_last = 1'b0;
        push_pad  = 1'b0;
        if (accept) begin
            case (state_q)
                S_HI: begin
                    if (in_last) begin
                        push      = 1'b1;
                        push_blk  = make_block(code, '0);
                        push_last = 1'b1;
                        push_pad  = 1'b1;
                    end else begin
                        hi_d    = code;
                        state_d = S_LO;
                    end
                end
                S_LO: begin
                    push      = 1'b1;
                    push_blk  = make_block(hi_q, code);
                    push_last = in_last;
                    state_d   = S_HI;
                end
                default: state_d = S_HI;
            endcase
        end
        blk_cnt_d = blk_cnt_q + CNT_W'(push);
        // Look ahead at this edge's push/pop so a full FIFO never sees another push.
        in_ready_d = !fifo_full_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_HI;
            in_ready_q <= 1'b0;
            blk_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            blk_cnt_q  <= blk_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        hi_q <= hi_d;
    end

    tg_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .wdata    ({push_last, push_pad, push_blk}),
        .pop      (out_ready),
        .rdata    (fifo_rdata),
        .empty    (fifo_empty),
        .full_nxt (fifo_full_nxt)
    );

    assign in_ready  = in_ready_q;
    assign blk_cnt   = blk_cnt_q;
    assign out_valid = !fifo_empty;
    assign out_last  = fifo_rdata[FW-1];
    assign out_pad   = fifo_rdata[FW-2];
    assign out_block = fifo_rdata[BLK_W-1:0];

`ifdef TG_ILLEGAL_CNT_EN
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
    logic             illegal_seen_q, illegal_seen_d;

    always_comb begin
        illegal_cnt_d  = illegal_cnt_q;
        illegal_seen_d = illegal_seen_q;
        if (accept && !tg_is_mapped(in_char)) begin
            illegal_seen_d = 1'b1;
            if (illegal_cnt_q != '1) illegal_cnt_d = illegal_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt_q  <= '0;
            illegal_seen_q <= 1'b0;
        end else begin
            illegal_cnt_q  <= illegal_cnt_d;
            illegal_seen_q <= illegal_seen_d;
        end
    end

    assign illegal_cnt  = illegal_cnt_q;
    assign illegal_seen = illegal_seen_q;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && out_valid)
            assert (out_block < BLK_W'(RSA_N))
            else $error("tg_pair_packer: block %0d not below RSA modulus", out_block);
    end
`endif

endmodule

// File: tb/tb_tg_pair_packer.sv
// Scoreboard bench for tg_pair_packer: directed message scenarios plus a long random
// stream with random downstream backpressure.
module tb_tg_pair_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_char = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [13:0] out_block;
    logic        out_last;
    logic        out_pad;
    logic [15:0] blk_cnt;
`ifdef TG_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt;
    logic        illegal_seen;
`endif

    tg_pair_packer #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_char   (in_char),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .out_last  (out_last),
        .out_pad   (out_pad),
        .blk_cnt   (blk_cnt)
`ifdef TG_ILLEGAL_CNT_EN
        ,
        .illegal_cnt  (illegal_cnt),
        .illegal_seen (illegal_seen)
`endif
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] sb_q[$];          // {last, pad, block}
    bit          auto_model = 1'b0;
    bit          m_lo = 1'b0;
    logic [5:0]  m_hi = '0;
    int          m_cnt = 0;
    int          m_ill = 0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_word = '0;

    function automatic int ref_code(input logic [6:0] c);
        string alpha;
        alpha = " !0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz";
        for (int i = 0; i < alpha.len(); i++)
            if (alpha[i] == {1'b0, c}) return i;
        return -1;
    endfunction

    task automatic model_accept(input logic [6:0] c, input logic l);
        int k;
        logic [5:0] cd;
        k = ref_code(c);
        if (k < 0) begin m_ill++; cd = 6'd0; end
        else cd = 6'(k);
        if (!m_lo) begin
            if (l) begin
                sb_q.push_back({1'b1, 1'b1, 14'(int'(cd) * 128)});
                m_cnt++;
            end else begin
                m_hi = cd;
                m_lo = 1'b1;
            end
        end else begin
            sb_q.push_back({l, 1'b0, 14'(int'(m_hi) * 128 + int'(cd))});
            m_cnt++;
            m_lo = 1'b0;
        end
    endtask

    // Output monitor, sampling 1 time unit before each rising edge.
    initial begin
        logic [15:0] got, exp;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                got = {out_last, out_pad, out_block};
                if (prev_stall) begin
                    vectors++;
                    if (!out_valid || got !== prev_word) begin
                        miscompares++;
                        $display("FAIL stall_stable: got valid=%b word=%h, required valid=1 word=%h",
                                 out_valid, got, prev_word);
                    end
                end
                if (out_valid && out_ready) begin
                    vectors++;
                    if (sb_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_block: got block=%0d last=%b pad=%b, required none",
                                 out_block, out_last, out_pad);
                    end else begin
                        exp = sb_q.pop_front();
                        if (got !== exp || out_block >= 14'd10403) begin
                            miscompares++;
                            $display("FAIL block: got block=%0d last=%b pad=%b, required block=%0d last=%b pad=%b",
                                     out_block, out_last, out_pad, exp[13:0], exp[15], exp[14]);
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_word  = got;
            end
        end
    end

    task automatic send_char(input logic [6:0] c, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_char  = c;
        in_last  = l;
        while (in_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got in_ready=%b, required 1 within 500 cycles", in_ready);
            in_valid = 1'b0;
            return;
        end
        if (auto_model) model_accept(c, l);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d blocks outstanding, required 0", sb_q.size());
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sb_q.delete();
        m_lo = 1'b0;
        m_cnt = 0;
        m_ill = 0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_cnt(input string name, input logic [15:0] req);
        vectors++;
        if (blk_cnt !== req) begin
            miscompares++;
            $display("FAIL %s: got blk_cnt=%0d, required %0d", name, blk_cnt, req);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_block !== 14'd0 ||
            out_last !== 1'b0 || out_pad !== 1'b0 || blk_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_values: got rdy=%b vld=%b blk=%0d last=%b pad=%b cnt=%0d, required all 0",
                     in_ready, out_valid, out_block, out_last, out_pad, blk_cnt);
        end
`ifdef TG_ILLEGAL_CNT_EN
        vectors++;
        if (illegal_cnt !== 16'd0 || illegal_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_illegal: got cnt=%0d seen=%b, required 0 0", illegal_cnt, illegal_seen);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_hi();
        do_reset();
        out_ready = 1'b1;
        sb_q.push_back({1'b1, 1'b0, 14'd2478});
        send_char(7'd72, 1'b0);
        send_char(7'd105, 1'b1);
        wait_drain();
        check_cnt("hi_cnt", 16'd1);
    endtask

    task automatic test_odd_pad();
        do_reset();
        out_ready = 1'b1;
        sb_q.push_back({1'b0, 1'b0, 14'd4903});
        sb_q.push_back({1'b1, 1'b1, 14'd5120});
        send_char(7'd97, 1'b0);
        send_char(7'd98, 1'b0);
        send_char(7'd99, 1'b1);
        wait_drain();
        check_cnt("abc_cnt", 16'd2);
    endtask

    task automatic test_backpressure();
        byte b;
        string s;
        s = "ABCDEFGHIJ";
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            sb_q.push_back({(i == 4), 1'b0, 14'((12 + 2 * i) * 128 + 13 + 2 * i)});
        for (int i = 0; i < 8; i++) begin
            b = s[i];
            send_char(b[6:0], 1'b0);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_ready: got in_ready=%b, required 0", in_ready);
        end
        b = s[8];
        in_valid = 1'b1;
        in_char = b[6:0];
        in_last = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || blk_cnt !== 16'd4 || out_valid !== 1'b1 || out_block !== 14'd1549) begin
            miscompares++;
            $display("FAIL stall_state: got rdy=%b cnt=%0d vld=%b blk=%0d, required 0 4 1 1549",
                     in_ready, blk_cnt, out_valid, out_block);
        end
        out_ready = 1'b1;
        send_char(b[6:0], 1'b0);
        b = s[9];
        send_char(b[6:0], 1'b1);
        wait_drain();
        check_cnt("bp_cnt", 16'd5);
    endtask

    task automatic test_illegal();
        do_reset();
        out_ready = 1'b1;
        sb_q.push_back({1'b1, 1'b0, 14'd63});
        send_char(7'd35, 1'b0);
        send_char(7'd122, 1'b1);
        wait_drain();
        check_cnt("illegal_blk_cnt", 16'd1);
`ifdef TG_ILLEGAL_CNT_EN
        vectors++;
        if (illegal_cnt !== 16'd1 || illegal_seen !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_cnt: got cnt=%0d seen=%b, required 1 1", illegal_cnt, illegal_seen);
        end
`endif
    endtask

    task automatic test_reset_midpair();
        do_reset();
        out_ready = 1'b1;
        send_char(7'd65, 1'b0);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got in_ready=%b, required 0", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sb_q.push_back({1'b1, 1'b0, 14'd267});
        send_char(7'd48, 1'b0);
        send_char(7'd57, 1'b1);
        wait_drain();
        check_cnt("midpair_cnt", 16'd1);
    endtask

    task automatic test_random();
        bit done;
        done = 1'b0;
        do_reset();
        auto_model = 1'b1;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    send_char(7'($urandom_range(0, 127)), ($urandom_range(0, 7) == 0) || (i == 9999));
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    @(negedge clk);
                end
            end
        join
        out_ready = 1'b1;
        auto_model = 1'b0;
        wait_drain();
        check_cnt("random_cnt", 16'(m_cnt));
`ifdef TG_ILLEGAL_CNT_EN
        vectors++;
        if (illegal_cnt !== 16'(m_ill) || illegal_seen !== (m_ill > 0)) begin
            miscompares++;
            $display("FAIL random_illegal: got cnt=%0d seen=%b, required %0d", illegal_cnt, illegal_seen, m_ill);
        end
`endif
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_hi();
        test_odd_pad();
        test_backpressure();
        test_illegal();
        test_reset_midpair();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tg_pair_packer.md
Name: tg_pair_packer

Overview:
Upstream feeder for the RSA encrypt stage. Accepts a 7-bit ASCII character stream over a valid/ready handshake and maps each character to a 6-bit tgBASE code. Pairs consecutive codes into one 14-bit plaintext block and buffers the blocks in a small FIFO. The encryptor pops these blocks over a second valid/ready handshake.

Parameters:
FIFO_DEPTH, 4, number of buffered output blocks; must be a power of 2 and at least 2.
CNT_W, 16, width of the block counter.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  in_char/in_last are valid.
in_ready  out  1  packer can accept a character.
in_char  in  7  ASCII character.
in_last  in  1  last character of the message.
out_valid  out  1  FIFO head is valid.
out_ready  in  1  downstream encryptor accepts the block.
out_block  out  14  {1'b0, hi_code[5:0], 1'b0, lo_code[5:0]}.
out_last  out  1  block carries the message's last character.
out_pad  out  1  lo half is padding (odd-length message).
blk_cnt  out  CNT_W  blocks pushed since reset; wraps at 2^CNT_W.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Outputs: in_ready=0, out_valid=0, out_block=0, out_last=0, out_pad=0, blk_cnt=0.
  - FIFO pointers cleared; held hi code discarded; FSM returns to S_HI.
  - A reset mid-pair or mid-message drops all partial state; no block is emitted for it.
- in_ready = !fifo_full, registered. It goes to 1 the first cycle after reset is released.
- A character is accepted on a clk edge when in_valid && in_ready.
- tgBASE map (combinational):
  - 32..33 -> 0..1
  - 48..57 -> 2..11
  - 65..90 -> 12..37
  - 97..122 -> 38..63
  - any other character -> 0
- FSM:
  - S_HI, accept with in_last=0: latch code as hi, go to S_LO.
  - S_HI, accept with in_last=1: push {0,hi,0,0} with pad=1, last=1; stay in S_HI.
  - S_LO, accept: push {0,hi,0,code} with pad=0, last=in_last; go to S_HI.
  - No accept: state holds.
- Each push increments blk_cnt by 1.
- FIFO:
  - Registered, no bypass. A character accepted at edge t completes its block, which appears on out_valid at t+1.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop when full is not possible, because in_ready=0 when full.
  - Simultaneous push and pop when not full leaves the occupancy unchanged.
  - Empty: out_valid=0; out_block/out_last/out_pad hold their last values.
  - Pointers wrap modulo FIFO_DEPTH.
- out_block and out_last/out_pad must stay stable while out_valid=1 and out_ready=0.
- Range guarantee: the maximum block is 63*128+63 = 8127, which is below RSA_N = 10403. A simulation assertion flags any out_block >= RSA_N.

Optional Feature:
TG_ILLEGAL_CNT_EN
- Defined: adds output port illegal_cnt[CNT_W-1:0] (reset 0). It increments on every accepted character outside the four mapped ranges, saturating at all-ones. A sticky illegal_seen bit (reset 0) is set on the first such character.
- Undefined: neither port exists; illegal characters map silently to code 0.

Decomposition:
- Package tg_pkg holds:
  - Constants TG_W=6, BLK_W=14, RSA_N=10403.
  - The ASCII range bounds and per-range offsets (32, 46, 53, 59).
  - Function ascii_to_tg and a typedef for the 14-bit block.
  - The FSM state enum {S_HI, S_LO}.
- One sub-module: tg_sync_fifo (parameterised width/depth, full/empty flags, async active-low reset).

Test Plan:
- "Hi", in_last on 'i', out_ready=1 -> one block 2478 (19*128+46), out_last=1, out_pad=0, blk_cnt=1.
- "abc", last on 'c' -> blocks 4903 then 5120 with pad=1 and last=1; blk_cnt=2.
- out_ready=0 while feeding 10 chars with DEPTH=4 -> in_ready drops after the 8th accept and the 9th char stalls. Then raise out_ready -> all 5 blocks emerge in order, and blocks stay stable during the stall.
- "#z" with the macro defined -> block 63 (0*128+63); illegal_cnt=1, illegal_seen=1. Without the macro, same block and no extra ports.
- Reset asserted after 'A' in S_LO, then "09" sent -> no block containing 'A'; single block 267 (2*128+11); blk_cnt=1.
- Random ASCII stream with random out_ready over 10k chars -> scoreboard matches the software model, and no out_block >= 10403.
